wdt_window: RTL and testbench
=============================

WDT_WINDOW -- requirements
Module: wdt_window

Interface
REQ-001 Parameter CNT_W, default 32: width of the timeout down-counter and the load and window values.
REQ-002 Parameter PRE_W, default 8: width of the clock prescaler.
REQ-003 Parameter RST_LEN, default 16: number of cycles timeout stays asserted per expiry, 1..2^16-1.
REQ-004 Port clk  input  1: single clock, all logic on the rising edge.
REQ-005 Port rst_  input  1: asynchronous reset, active-low.
REQ-006 Port en  input  1: watchdog enable level.
REQ-007 Port feed  input  1: one-cycle feed (kick) strobe.
REQ-008 Port cfg_we  input  1: write strobe for the cfg_* shadow registers.
REQ-009 Port cfg_load  input  CNT_W: reload value.
REQ-010 Port cfg_window  input  CNT_W: window threshold; a feed is legal only when count <= window.
REQ-011 Port cfg_win_en  input  1: window checking enable.
REQ-012 Port cfg_pre  input  PRE_W: prescale value; the counter ticks every cfg_pre+1 cycles.
REQ-013 Port cfg_stages  input  2: number of interrupt expiries (0..3) allowed before reset.
REQ-014 Port lock  input  1: sticky lock request.
REQ-015 Port intr  output  1: pre-reset warning interrupt, a level.
REQ-016 Port timeout  output  1: system reset request, a level.
REQ-017 Port win_err  output  1: one-cycle pulse on an early (out-of-window) feed.
REQ-018 Port cfg_err  output  1: one-cycle pulse on cfg_we or en deassertion while locked.
REQ-019 Port count_o  output  CNT_W: current counter value.
REQ-020 Port stage_o  output  2: number of interrupt expiries since the last feed.

Function
REQ-021 FSM states SHALL be IDLE, RUN and EXPIRED.
- IDLE->RUN when en=1; count loads load_val.
- RUN->IDLE when en=0 and unlocked.
- RUN->EXPIRED on final expiry or on an early feed.
- EXPIRED->RUN (en=1) or IDLE (en=0) after RST_LEN cycles; count reloads and stage clears.
REQ-022 cfg_we=1 with locked=0 SHALL capture load_val, win_val, win_en, pre_val and stages the next cycle; new values take effect at the next reload or next prescaler compare.
REQ-023 lock=1 SHALL set locked; locked clears only on reset.
REQ-024 While locked, cfg_we SHALL be ignored and SHALL pulse cfg_err.
REQ-025 While locked, en=0 SHALL be ignored (the FSM stays in RUN) and SHALL pulse cfg_err on the falling edge of en.
REQ-026 Prescaler pre_cnt SHALL run only in RUN, count 0..pre_val, assert tick when pre_cnt==pre_val, then wrap to 0; pre_val=0 gives a tick every cycle.
REQ-027 In RUN on a tick with count!=0, count SHALL decrement by 1.
REQ-028 In RUN on a tick with count==0 and stage<stages:
- intr=1, stage+1, count=load_val, pre_cnt=0.
REQ-029 In RUN on a tick with count==0 and stage>=stages:
- timeout=1, intr=0, enter EXPIRED.
REQ-030 feed in RUN with (win_en=0 or count<=win_val) SHALL set count=load_val, pre_cnt=0, stage=0 and intr=0.
REQ-031 feed in RUN with win_en=1 and count>win_val SHALL pulse win_err, set timeout=1 and enter EXPIRED.
REQ-032 feed in IDLE or EXPIRED SHALL be ignored.
REQ-033 Same-cycle priority SHALL be: EXPIRED sequencing > feed > tick; feed and an expiring tick together SHALL resolve as a feed.
REQ-034 In EXPIRED, timeout SHALL stay 1 for exactly RST_LEN cycles, counted by an internal counter; the counter and prescaler SHALL hold.
REQ-035 count SHALL never wrap below 0; all arithmetic is unsigned CNT_W bits.
REQ-036 Outputs SHALL be registered; count_o and stage_o reflect the registered state.

Reset
REQ-037 rst_=0 SHALL immediately force the following, independent of clk:
- state=IDLE, count=all ones, load_val=all ones, win_val=all ones, win_en=0;
- pre_val=0, stages=1, locked=0, pre_cnt=0, stage=0;
- intr=0, timeout=0, win_err=0, cfg_err=0.
REQ-038 Reset asserted mid-EXPIRED SHALL deassert timeout immediately; after release the block returns to IDLE.

Verification (CNT_W=8, RST_LEN=4)
REQ-039 cfg_load=5, pre=0, stages=0, en=1, no feed -> count 5..0, then timeout=1 for exactly 4 cycles, then count=5.
REQ-040 stages=2, load=3 -> intr rises at the first expiry, stage_o goes 1 then 2, timeout at the third expiry; a feed after the first intr -> intr=0, stage_o=0.
REQ-041 win_en=1, window=2, load=10; feed at count=7 -> win_err pulse and timeout; feed at count=2 -> count=10 and no error.
REQ-042 pre=3, load=2 -> count decrements every 4 cycles; feed and an expiring tick in the same cycle -> reload, no intr.
REQ-043 lock=1, then cfg_we with load=9 -> cfg_err pulse and load unchanged; en=0 -> cfg_err pulse and the FSM stays in RUN.
REQ-044 rst_ low during EXPIRED -> timeout drops asynchronously; all outputs match the REQ-037 values.

Source files
------------

// File: rtl/wdt_window.sv
// Windowed watchdog: prescaled timeout down-counter with staged warning
// interrupts, early-feed detection, a fixed-length reset pulse and a sticky config lock.
//
// state   | meaning
// IDLE    | watchdog disabled, counter and prescaler hold
// RUN     | counting down, accepting feeds
// EXPIRED | timeout asserted for RST_LEN cycles
module wdt_window #(
   parameter int CNT_W   = 32,
   parameter int PRE_W   = 8,
   parameter int RST_LEN = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             en,
   input  logic             feed,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_load,
   input  logic [CNT_W-1:0] cfg_window,
   input  logic             cfg_win_en,
   input  logic [PRE_W-1:0] cfg_pre,
   input  logic [1:0]       cfg_stages,
   input  logic             lock,
   output logic             intr,
   output logic             timeout,
   output logic             win_err,
   output logic             cfg_err,
   output logic [CNT_W-1:0] count_o,
   output logic [1:0]       stage_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam logic [15:0] RST_LOAD = 16'(RST_LEN - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] load_q, load_d;
   logic [CNT_W-1:0] win_q, win_d;
   logic             win_en_q, win_en_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [1:0]       stages_q, stages_d;
   logic             locked_q, locked_d;
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [1:0]       stage_q, stage_d;
   logic             intr_q, intr_d;
   logic             timeout_q, timeout_d;
   logic             win_err_q, win_err_d;
   logic             cfg_err_q, cfg_err_d;
   logic [15:0]      rst_cnt_q, rst_cnt_d;
   logic             en_q, en_d;
   logic             tick;

   // >= rather than == so a prescale shrunk below the running count still wraps
   assign tick = (pre_cnt_q >= pre_q);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q   <= IDLE;
         count_q   <= '1;
         load_q    <= '1;
         win_q     <= '1;
         win_en_q  <= 1'b0;
         pre_q     <= '0;
         stages_q  <= 2'd1;
         locked_q  <= 1'b0;
         pre_cnt_q <= '0;
         stage_q   <= 2'd0;
         intr_q    <= 1'b0;
         timeout_q <= 1'b0;
         win_err_q <= 1'b0;
         cfg_err_q <= 1'b0;
         rst_cnt_q <= '0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         load_q    <= load_d;
         win_q     <= win_d;
         win_en_q  <= win_en_d;
         pre_q     <= pre_d;
         stages_q  <= stages_d;
         locked_q  <= locked_d;
         pre_cnt_q <= pre_cnt_d;
         stage_q   <= stage_d;
         intr_q    <= intr_d;
         timeout_q <= timeout_d;
         win_err_q <= win_err_d;
         cfg_err_q <= cfg_err_d;
         rst_cnt_q <= rst_cnt_d;
         en_q      <= en_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      load_d    = load_q;
      win_d     = win_q;
      win_en_d  = win_en_q;
      pre_d     = pre_q;
      stages_d  = stages_q;
      locked_d  = locked_q | lock;
      pre_cnt_d = pre_cnt_q;
      stage_d   = stage_q;
      intr_d    = intr_q;
      timeout_d = timeout_q;
      win_err_d = 1'b0;
      cfg_err_d = 1'b0;
      rst_cnt_d = rst_cnt_q;
      en_d      = en;

      if (cfg_we) begin
         if (locked_q) begin
            cfg_err_d = 1'b1;
         end else begin
            load_d   = cfg_load;
            win_d    = cfg_window;
            win_en_d = cfg_win_en;
            pre_d    = cfg_pre;
            stages_d = cfg_stages;
         end
      end
      if (locked_q && en_q && !en) cfg_err_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d   = RUN;
               count_d   = load_q;
               pre_cnt_d = '0;
               stage_d   = 2'd0;
            end
         end
         RUN: begin
            if (!en && !locked_q) begin
               state_d = IDLE;
               intr_d  = 1'b0;
            end else if (feed) begin
               if (win_en_q && (count_q > win_q)) begin
                  win_err_d = 1'b1;
                  timeout_d = 1'b1;
                  intr_d    = 1'b0;
                  rst_cnt_d = RST_LOAD;
                  state_d   = EXPIRED;
               end else begin
                  count_d   = load_q;
                  pre_cnt_d = '0;
                  stage_d   = 2'd0;
                  intr_d    = 1'b0;
               end
            end else if (tick) begin
               pre_cnt_d = '0;
               if (count_q != '0) begin
                  count_d = count_q - CNT_W'(1);
               end else if (stage_q < stages_q) begin
                  intr_d  = 1'b1;
                  stage_d = stage_q + 2'd1;
                  count_d = load_q;
               end else begin
                  timeout_d = 1'b1;
                  intr_d    = 1'b0;
                  rst_cnt_d = RST_LOAD;
                  state_d   = EXPIRED;
               end
            end else begin
               pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
         end
         EXPIRED: begin
            if (rst_cnt_q == '0) begin
               timeout_d = 1'b0;
               count_d   = load_q;
               stage_d   = 2'd0;
               pre_cnt_d = '0;
               state_d   = (en || locked_q) ? RUN : IDLE;
            end else begin
               rst_cnt_d = rst_cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign intr    = intr_q;
   assign timeout = timeout_q;
   assign win_err = win_err_q;
   assign cfg_err = cfg_err_q;
   assign count_o = count_q;
   assign stage_o = stage_q;

endmodule

// File: tb/tb_wdt_window.sv
// Directed bench for wdt_window at CNT_W=8, RST_LEN=4; all expectations hand-computed.
module tb_wdt_window;

   logic       clk;
   logic       rst_;
   logic       en;
   logic       feed;
   logic       cfg_we;
   logic [7:0] cfg_load;
   logic [7:0] cfg_window;
   logic       cfg_win_en;
   logic [7:0] cfg_pre;
   logic [1:0] cfg_stages;
   logic       lock;
   logic       intr;
   logic       timeout;
   logic       win_err;
   logic       cfg_err;
   logic [7:0] count_o;
   logic [1:0] stage_o;

   int n_chk  = 0;
   int n_fail = 0;

   wdt_window #(.CNT_W(8), .PRE_W(8), .RST_LEN(4)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .en        (en),
      .feed      (feed),
      .cfg_we    (cfg_we),
      .cfg_load  (cfg_load),
      .cfg_window(cfg_window),
      .cfg_win_en(cfg_win_en),
      .cfg_pre   (cfg_pre),
      .cfg_stages(cfg_stages),
      .lock      (lock),
      .intr      (intr),
      .timeout   (timeout),
      .win_err   (win_err),
      .cfg_err   (cfg_err),
      .count_o   (count_o),
      .stage_o   (stage_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"},   32'(count_o), 255);
      chk({tag, "_stage"},   32'(stage_o), 0);
      chk({tag, "_intr"},    32'(intr), 0);
      chk({tag, "_timeout"}, 32'(timeout), 0);
      chk({tag, "_win_err"}, 32'(win_err), 0);
      chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
   endtask

   task automatic do_reset();
      rst_ = 1'b0;
      en = 1'b0; feed = 1'b0; cfg_we = 1'b0; lock = 1'b0;
      @(posedge clk);
      #1;
      rst_ = 1'b1;
   endtask

   task automatic cfg_write(input logic [7:0] ld, input logic [7:0] win, input logic we_win,
                            input logic [7:0] pre, input logic [1:0] stg);
      cfg_load = ld; cfg_window = win; cfg_win_en = we_win; cfg_pre = pre; cfg_stages = stg;
      cfg_we = 1'b1;
      step(1);
      cfg_we = 1'b0;
   endtask

   initial begin
      rst_ = 1'b1;
      en = 1'b0; feed = 1'b0; cfg_we = 1'b0; lock = 1'b0;
      cfg_load = '0; cfg_window = '0; cfg_win_en = 1'b0; cfg_pre = '0; cfg_stages = '0;

      // asynchronous reset with no clock edge in between
      #3 rst_ = 1'b0;
      #1 chk_reset_vals("rst");
      @(posedge clk);
      #1 rst_ = 1'b1;

      // basic expiry with no stages
      cfg_write(8'd5, 8'd255, 1'b0, 8'd0, 2'd0);
      en = 1'b1;
      step(1);
      chk("t1_load", 32'(count_o), 5);
      for (int k = 4; k >= 0; k--) begin
         step(1);
         chk("t1_cnt", 32'(count_o), 32'(k));
         chk("t1_to_low", 32'(timeout), 0);
      end
      for (int k = 0; k < 4; k++) begin
         step(1);
         chk("t1_to_high", 32'(timeout), 1);
         chk("t1_cnt_hold", 32'(count_o), 0);
      end
      step(1);
      chk("t1_to_end", 32'(timeout), 0);
      chk("t1_reload", 32'(count_o), 5);
      en = 1'b0;
      step(1);
      chk("t1_idle_a", 32'(count_o), 5);
      step(1);
      chk("t1_idle_b", 32'(count_o), 5);

      // staged interrupts
      do_reset();
      cfg_write(8'd3, 8'd255, 1'b0, 8'd0, 2'd2);
      en = 1'b1;
      step(1);
      chk("t2_load", 32'(count_o), 3);
      step(3);
      chk("t2_zero", 32'(count_o), 0);
      chk("t2_no_intr", 32'(intr), 0);
      step(1);
      chk("t2_intr1", 32'(intr), 1);
      chk("t2_stage1", 32'(stage_o), 1);
      chk("t2_reload1", 32'(count_o), 3);
      step(4);
      chk("t2_intr2", 32'(intr), 1);
      chk("t2_stage2", 32'(stage_o), 2);
      chk("t2_to_before", 32'(timeout), 0);
      step(4);
      chk("t2_timeout", 32'(timeout), 1);
      chk("t2_intr_clr", 32'(intr), 0);

      do_reset();
      cfg_write(8'd3, 8'd255, 1'b0, 8'd0, 2'd2);
      en = 1'b1;
      step(5);
      chk("t2b_intr", 32'(intr), 1);
      step(1);
      chk("t2b_cnt", 32'(count_o), 2);
      feed = 1'b1;
      step(1);
      feed = 1'b0;
      chk("t2b_feed_cnt", 32'(count_o), 3);
      chk("t2b_feed_stage", 32'(stage_o), 0);
      chk("t2b_feed_intr", 32'(intr), 0);

      // window: early feed, then feed exactly at the window
      do_reset();
      cfg_write(8'd10, 8'd2, 1'b1, 8'd0, 2'd0);
      en = 1'b1;
      step(4);
      chk("t3_cnt7", 32'(count_o), 7);
      feed = 1'b1;
      step(1);
      feed = 1'b0;
      chk("t3_win_err", 32'(win_err), 1);
      chk("t3_timeout", 32'(timeout), 1);
      chk("t3_hold", 32'(count_o), 7);
      step(1);
      chk("t3_win_err_pulse", 32'(win_err), 0);
      chk("t3_timeout_hold", 32'(timeout), 1);

      do_reset();
      cfg_write(8'd10, 8'd2, 1'b1, 8'd0, 2'd0);
      en = 1'b1;
      step(9);
      chk("t3b_cnt2", 32'(count_o), 2);
      feed = 1'b1;
      step(1);
      feed = 1'b0;
      chk("t3b_reload", 32'(count_o), 10);
      chk("t3b_no_err", 32'(win_err), 0);
      chk("t3b_no_to", 32'(timeout), 0);

      // prescaler and feed colliding with an expiring tick
      do_reset();
      cfg_write(8'd2, 8'd255, 1'b0, 8'd3, 2'd1);
      en = 1'b1;
      step(1);
      chk("t4_load", 32'(count_o), 2);
      step(3);
      chk("t4_hold3", 32'(count_o), 2);
      step(1);
      chk("t4_dec", 32'(count_o), 1);
      step(4);
      chk("t4_zero", 32'(count_o), 0);
      step(3);
      chk("t4_zero_hold", 32'(count_o), 0);
      chk("t4_no_intr", 32'(intr), 0);
      feed = 1'b1;
      step(1);
      feed = 1'b0;
      chk("t4_feed_cnt", 32'(count_o), 2);
      chk("t4_feed_intr", 32'(intr), 0);
      chk("t4_feed_stage", 32'(stage_o), 0);

      // lock
      do_reset();
      cfg_write(8'd4, 8'd255, 1'b0, 8'd0, 2'd0);
      lock = 1'b1;
      en = 1'b1;
      step(1);
      lock = 1'b0;
      chk("t5_load", 32'(count_o), 4);
      cfg_load = 8'd9;
      cfg_we = 1'b1;
      step(1);
      cfg_we = 1'b0;
      chk("t5_cfg_err", 32'(cfg_err), 1);
      chk("t5_cnt3", 32'(count_o), 3);
      step(1);
      chk("t5_cfg_err_pulse", 32'(cfg_err), 0);
      en = 1'b0;
      step(1);
      chk("t5_en_err", 32'(cfg_err), 1);
      chk("t5_still_run", 32'(count_o), 1);
      feed = 1'b1;
      step(1);
      feed = 1'b0;
      chk("t5_load_kept", 32'(count_o), 4);
      chk("t5_en_err_pulse", 32'(cfg_err), 0);

      // reset in the middle of EXPIRED
      do_reset();
      cfg_write(8'd1, 8'd255, 1'b0, 8'd0, 2'd0);
      en = 1'b1;
      step(3);
      chk("t6_timeout", 32'(timeout), 1);
      #2 rst_ = 1'b0;
      #1 chk_reset_vals("t6_async");
      en = 1'b0;
      @(posedge clk);
      #1 rst_ = 1'b1;
      step(1);
      chk("t6_idle_cnt", 32'(count_o), 255);
      chk("t6_idle_to", 32'(timeout), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
